// File: rtl/cache_ctrl_dm.sv
// cache_ctrl_dm: direct-mapped, write-through, no-write-allocate byte cache
// sitting between a processor load/store port and main_memory.
//  clk, reset               clock / synchronous active-high reset
//  cpu_rd, cpu_wr           held requests (write wins when both set)
//  cpu_addr, cpu_wdata      request address / write data
//  cpu_rdata, cpu_ready     read data / one-cycle completion pulse
//  rd_mem, wr_mem           memory read / write requests
//  addr_mem, mem_wdata      memory address / write data
//  mem_rdata, ready_mem     memory read data / idle(1) vs busy-acked(0)
//  hit_cnt, miss_cnt        saturating read hit / miss counters
module cache_ctrl_dm #(
  parameter int AWIDTH   = 9,
  parameter int DWIDTH   = 8,
  parameter int INDEX_W  = 4,
  parameter int MEM_WAIT = 2,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [AWIDTH-1:0] cpu_addr,
  input  logic [DWIDTH-1:0] cpu_wdata,
  output logic [DWIDTH-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              rd_mem,
  output logic              wr_mem,
  output logic [AWIDTH-1:0] addr_mem,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata,
  input  logic              ready_mem,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int LINES  = 1 << INDEX_W;
  localparam int TAG_W  = AWIDTH - INDEX_W;
  localparam int WAIT_W = $clog2(MEM_WAIT + 2);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] RD_REQ    = 3'd1;
  localparam logic [2:0] RD_WAIT   = 3'd2;
  localparam logic [2:0] WR_REQ    = 3'd3;
  localparam logic [2:0] WR_WAIT   = 3'd4;
  localparam logic [2:0] MEM_DRAIN = 3'd5;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [2:0]                   state;
  logic [WAIT_W-1:0]            wait_cnt;
  logic [LINES-1:0]             valid;
  logic [LINES-1:0][TAG_W-1:0]  tags;
  logic [LINES-1:0][DWIDTH-1:0] lines;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic               hit;
  logic               line_we;
  logic [DWIDTH-1:0]  line_wdata;
  logic               fill;

  always_comb begin
    idx = cpu_addr[INDEX_W-1:0];
    tag = cpu_addr[AWIDTH-1:INDEX_W];
    hit = valid[idx] && (tags[idx] == tag);
  end

  // Line writes: a read fill at the end of RD_WAIT, or a write-through
  // update of an already-present line when the memory acks the write.
  always_comb begin
    fill       = (state == RD_WAIT) && (wait_cnt == '0);
    line_we    = 1'b0;
    line_wdata = mem_rdata;
    if (!reset) begin
      if (fill) begin
        line_we = 1'b1;
      end else if ((state == WR_REQ) && !ready_mem && hit) begin
        line_we    = 1'b1;
        line_wdata = cpu_wdata;
      end
    end
  end

  // Tag/data storage needs no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tags[idx]  <= tag;
      lines[idx] <= line_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      valid     <= '0;
      cpu_rdata <= '0;
      cpu_ready <= 1'b0;
      rd_mem    <= 1'b0;
      wr_mem    <= 1'b0;
      addr_mem  <= '0;
      mem_wdata <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      cpu_ready <= 1'b0;
      case (state)
        IDLE: begin
          // cpu_ready high means the cpu is still holding the request just
          // completed; it must not be accepted a second time.
          if (ready_mem && !cpu_ready && (cpu_rd || cpu_wr)) begin
            if (cpu_wr) begin
              state     <= WR_REQ;
              wr_mem    <= 1'b1;
              addr_mem  <= cpu_addr;
              mem_wdata <= cpu_wdata;
            end else if (hit) begin
              cpu_rdata <= lines[idx];
              cpu_ready <= 1'b1;
              if (hit_cnt != CNT_MAX) hit_cnt <= hit_cnt + 1'b1;
            end else begin
              state    <= RD_REQ;
              rd_mem   <= 1'b1;
              addr_mem <= cpu_addr;
              if (miss_cnt != CNT_MAX) miss_cnt <= miss_cnt + 1'b1;
            end
          end
        end
        RD_REQ: begin
          if (!ready_mem) begin
            state    <= RD_WAIT;
            wait_cnt <= WAIT_W'(MEM_WAIT);
          end
        end
        RD_WAIT: begin
          if (fill) begin
            valid[idx] <= 1'b1;
            cpu_rdata  <= mem_rdata;
            cpu_ready  <= 1'b1;
            rd_mem     <= 1'b0;
            state      <= MEM_DRAIN;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        WR_REQ: begin
          if (!ready_mem) begin
            wr_mem <= 1'b0;
            state  <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          cpu_ready <= 1'b1;
          state     <= MEM_DRAIN;
        end
        MEM_DRAIN: begin
          if (ready_mem) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl_dm.sv
module tb_cache_ctrl_dm;
  localparam int CNT_W = 3;

  typedef struct {
    logic       rd;
    logic       wr;
    logic [8:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    logic       exp_hit;
    int         exp_rdm;
    int         exp_wrm;
  } vec_t;

  typedef struct {
    logic       is_rd;
    logic [7:0] rdata;
    int         id;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [8:0]       cpu_addr = '0;
  logic [7:0]       cpu_wdata = '0;
  logic [7:0]       cpu_rdata;
  logic             cpu_ready;
  logic             rd_mem, wr_mem;
  logic [8:0]       addr_mem;
  logic [7:0]       mem_wdata;
  logic [7:0]       mem_rdata;
  logic             ready_mem;
  logic [CNT_W-1:0] hit_cnt, miss_cnt;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];

  cache_ctrl_dm #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready), .rd_mem(rd_mem), .wr_mem(wr_mem),
    .addr_mem(addr_mem), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .ready_mem(ready_mem), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  // Main memory model: acks a request by dropping ready_mem for 5 cycles.
  logic [7:0] mem [0:511];
  logic       mem_loaded = 1'b0;
  int         bcnt = 0;
  int         rd_acks = 0, wr_acks = 0;

  assign mem_rdata = mem[addr_mem];

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 512; i++) mem[i] <= 8'(i) ^ 8'hC3;
      mem[9'h005] <= 8'hA5;
      mem[9'h015] <= 8'h77;
      mem[9'h020] <= 8'h11;
      mem[9'h030] <= 8'h22;
      mem_loaded  <= 1'b1;
    end
    if (reset) begin
      ready_mem <= 1'b1;
      bcnt      <= 0;
    end else if (bcnt != 0) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) ready_mem <= 1'b1;
    end else if ((rd_mem || wr_mem) && ready_mem) begin
      ready_mem <= 1'b0;
      bcnt      <= 5;
      if (wr_mem) begin
        mem[addr_mem] <= mem_wdata;
        wr_acks <= wr_acks + 1;
      end else begin
        rd_acks <= rd_acks + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every completion pulse pops one expectation.
  always @(negedge clk) begin
    if (cpu_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_cpu_ready", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.is_rd) chk($sformatf("rdata_v%0d", e.id), 32'(cpu_rdata), 32'(e.rdata));
      end
    end
  end

  task automatic run_vec(input vec_t v, input int id);
    int r0, w0, lat;
    bit got;
    exp_t e;
    e.is_rd = v.rd && !v.wr;
    e.rdata = v.exp_rdata;
    e.id    = id;
    sb.push_back(e);
    r0 = rd_acks;
    w0 = wr_acks;
    cpu_rd    = v.rd;
    cpu_wr    = v.wr;
    cpu_addr  = v.addr;
    cpu_wdata = v.wdata;
    got = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40 && !got; n++) begin
      @(posedge clk); #1;
      if (cpu_ready) begin
        got = 1'b1;
        lat = n;
      end
    end
    chk($sformatf("ready_seen_v%0d", id), 32'(got), 32'd1);
    if (!got) sb.delete();
    @(posedge clk); #1;
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk($sformatf("hit_latency_v%0d", id), 32'(lat == 1), 32'(v.exp_hit));
    chk($sformatf("rd_mem_issues_v%0d", id), 32'(rd_acks - r0), 32'(v.exp_rdm));
    chk($sformatf("wr_mem_issues_v%0d", id), 32'(wr_acks - w0), 32'(v.exp_wrm));
  endtask

  vec_t vecs[14];

  initial begin
    int nhit, nmiss;
    bit seen;
    //         rd wr addr    wdata  exp   hit rdm wrm
    vecs[0]  = '{1, 0, 9'h005, 8'h00, 8'hA5, 0, 1, 0};
    vecs[1]  = '{1, 0, 9'h005, 8'h00, 8'hA5, 1, 0, 0};
    vecs[2]  = '{0, 1, 9'h005, 8'h3C, 8'h00, 0, 0, 1};
    vecs[3]  = '{1, 0, 9'h005, 8'h00, 8'h3C, 1, 0, 0};
    vecs[4]  = '{1, 0, 9'h015, 8'h00, 8'h77, 0, 1, 0};
    vecs[5]  = '{1, 0, 9'h005, 8'h00, 8'h3C, 0, 1, 0};
    vecs[6]  = '{1, 0, 9'h005, 8'h00, 8'h3C, 1, 0, 0};
    vecs[7]  = '{1, 1, 9'h020, 8'h55, 8'h00, 0, 0, 1};
    vecs[8]  = '{1, 0, 9'h020, 8'h00, 8'h55, 0, 1, 0};
    vecs[9]  = '{1, 0, 9'h020, 8'h00, 8'h55, 1, 0, 0};
    vecs[10] = '{0, 1, 9'h030, 8'h99, 8'h00, 0, 0, 1};
    vecs[11] = '{1, 0, 9'h020, 8'h00, 8'h55, 1, 0, 0};
    vecs[12] = '{1, 0, 9'h030, 8'h00, 8'h99, 0, 1, 0};
    vecs[13] = '{1, 0, 9'h030, 8'h00, 8'h99, 1, 0, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_cpu_ready", 32'(cpu_ready), 0);
    chk("reset_rd_mem", 32'(rd_mem), 0);
    chk("reset_wr_mem", 32'(wr_mem), 0);
    chk("reset_hit_cnt", 32'(hit_cnt), 0);
    chk("reset_miss_cnt", 32'(miss_cnt), 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    nhit = 0;
    nmiss = 0;
    foreach (vecs[i]) begin
      run_vec(vecs[i], i);
      if (vecs[i].rd && !vecs[i].wr) begin
        if (vecs[i].exp_hit) nhit++; else nmiss++;
      end
    end
    chk("hit_cnt_after_table", 32'(hit_cnt), 32'(nhit));
    chk("miss_cnt_after_table", 32'(miss_cnt), 32'(nmiss));

    // Saturation: 6 hits + 2 more reach 7 and stick; 5 misses + 3 more likewise.
    run_vec('{1, 0, 9'h030, 8'h00, 8'h99, 1, 0, 0}, 20);
    chk("hit_cnt_at_max", 32'(hit_cnt), 32'd7);
    run_vec('{1, 0, 9'h030, 8'h00, 8'h99, 1, 0, 0}, 21);
    chk("hit_cnt_saturated", 32'(hit_cnt), 32'd7);
    run_vec('{1, 0, 9'h040, 8'h00, 8'h83, 0, 1, 0}, 22);
    run_vec('{1, 0, 9'h050, 8'h00, 8'h93, 0, 1, 0}, 23);
    chk("miss_cnt_at_max", 32'(miss_cnt), 32'd7);
    run_vec('{1, 0, 9'h060, 8'h00, 8'hA3, 0, 1, 0}, 24);
    chk("miss_cnt_saturated", 32'(miss_cnt), 32'd7);

    // Reset while a read miss sits in RD_WAIT: no completion pulse must follow.
    cpu_rd = 1'b1;
    cpu_addr = 9'h045;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(posedge clk); #1;
      if (rd_mem && !ready_mem) seen = 1'b1;
    end
    chk("mid_read_ack_seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_rd_mem_low", 32'(rd_mem), 0);
    chk("abort_no_ready", 32'(cpu_ready), 0);
    cpu_rd = 1'b0;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_hit_cnt", 32'(hit_cnt), 0);
    chk("abort_miss_cnt", 32'(miss_cnt), 0);
    chk("abort_wr_mem_low", 32'(wr_mem), 0);
    run_vec('{1, 0, 9'h030, 8'h00, 8'h99, 0, 1, 0}, 30);
    run_vec('{1, 0, 9'h005, 8'h00, 8'h3C, 0, 1, 0}, 31);
    run_vec('{1, 0, 9'h030, 8'h00, 8'h99, 1, 0, 0}, 32);
    chk("post_abort_miss_cnt", 32'(miss_cnt), 32'd2);
    chk("post_abort_hit_cnt", 32'(hit_cnt), 32'd1);
    chk("scoreboard_drained", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
